regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_map.sv | 30 +++
 rtl/regfile.sv | 87 ++++++++
 tb/tb_regfile.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared ARM constants for the register file: CPSR mode encodings and
// the physical register layout (user bank, then FIQ, IRQ, SVC, ABT, UND banks).
package regfile_pkg;

  typedef enum logic [4:0] {
    MODE_USR = 5'b10000,
    MODE_FIQ = 5'b10001,
    MODE_IRQ = 5'b10010,
    MODE_SVC = 5'b10011,
    MODE_ABT = 5'b10111,
    MODE_UND = 5'b11011,
    MODE_SYS = 5'b11111
  } mode_e;

  localparam int unsigned NUM_PHYS = 30;

  localparam logic [4:0] FIQ_BASE  = 5'd15;  // r8_fiq..r14_fiq
  localparam logic [4:0] IRQ_BASE  = 5'd22;  // r13_irq, r14_irq
  localparam logic [4:0] SVC_BASE  = 5'd24;
  localparam logic [4:0] ABT_BASE  = 5'd26;
  localparam logic [4:0] UND_BASE  = 5'd28;
  localparam logic [4:0] PHYS_NONE = 5'd31;  // r15: no physical storage

endpackage

// File: rtl/regfile_map.sv
// Combinational (architectural index, mode) -> physical register index.
// Unlisted modes fall back to the user bank; r15 maps to PHYS_NONE.
module regfile_map
  import regfile_pkg::*;
(
  input  logic [3:0] idx,
  input  logic [4:0] mode,
  output logic [4:0] phys
);

  logic [4:0] idx5;
  assign idx5 = {1'b0, idx};

  always_comb begin
    phys = idx5;
    if (idx == 4'hF) begin
      phys = PHYS_NONE;
    end else begin
      case (mode_e'(mode))
        MODE_FIQ: if (idx >= 4'd8)  phys = FIQ_BASE + (idx5 - 5'd8);
        MODE_IRQ: if (idx >= 4'd13) phys = IRQ_BASE + (idx5 - 5'd13);
        MODE_SVC: if (idx >= 4'd13) phys = SVC_BASE + (idx5 - 5'd13);
        MODE_ABT: if (idx >= 4'd13) phys = ABT_BASE + (idx5 - 5'd13);
        MODE_UND: if (idx >= 4'd13) phys = UND_BASE + (idx5 - 5'd13);
        default:  phys = idx5;
      endcase
    end
  end

endmodule

// File: rtl/regfile.sv
// Banked ARM register file: three combinational read ports with write
// bypass, one write port, and a one-bit-per-register producer scoreboard.
module regfile
  import regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic [4:0]  mode,
  input  logic [3:0]  read_0,
  input  logic [3:0]  read_1,
  input  logic [3:0]  read_2,
  output logic [31:0] rdata_0,
  output logic [31:0] rdata_1,
  output logic [31:0] rdata_2,
  output logic        busy_0,
  output logic        busy_1,
  output logic        busy_2,
  input  logic        write_en,
  input  logic [3:0]  write_reg,
  input  logic [4:0]  write_mode,
  input  logic [31:0] write_data,
  input  logic        set_en,
  input  logic [3:0]  set_reg
);

  logic [31:0]         regs [NUM_PHYS];
  logic [NUM_PHYS-1:0] busy_q;

  logic [4:0]  rp [3];
  logic [4:0]  wp;
  logic [4:0]  sp;
  logic        wr_hit;
  logic        set_hit;
  logic [31:0] rdata_a [3];
  logic        busy_a  [3];

  regfile_map u_map_r0 (.idx(read_0),    .mode(mode),       .phys(rp[0]));
  regfile_map u_map_r1 (.idx(read_1),    .mode(mode),       .phys(rp[1]));
  regfile_map u_map_r2 (.idx(read_2),    .mode(mode),       .phys(rp[2]));
  regfile_map u_map_w  (.idx(write_reg), .mode(write_mode), .phys(wp));
  regfile_map u_map_s  (.idx(set_reg),   .mode(mode),       .phys(sp));

  // Bypass is gated by rst_b so it never shows data that will not be stored.
  assign wr_hit  = rst_b && write_en && (wp != PHYS_NONE);
  assign set_hit = set_en && (sp != PHYS_NONE);

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      rdata_a[i] = '0;
      busy_a[i]  = 1'b0;
      if (rp[i] != PHYS_NONE) begin
        if (wr_hit && (wp == rp[i])) begin
          rdata_a[i] = write_data;
        end else begin
          rdata_a[i] = regs[rp[i]];
          busy_a[i]  = busy_q[rp[i]];
        end
      end
    end
  end

  assign rdata_0 = rdata_a[0];
  assign rdata_1 = rdata_a[1];
  assign rdata_2 = rdata_a[2];
  assign busy_0  = busy_a[0];
  assign busy_1  = busy_a[1];
  assign busy_2  = busy_a[2];

  // Set is applied after clear so it wins when both hit the same register.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i < NUM_PHYS; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_hit) begin
        regs[wp]   <= write_data;
        busy_q[wp] <= 1'b0;
      end
      if (set_hit) begin
        busy_q[sp] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: banking, bypass, scoreboard,
// r15 handling and synchronous reset.
module tb_regfile;

  localparam logic [4:0] USR = 5'b10000;
  localparam logic [4:0] FIQ = 5'b10001;
  localparam logic [4:0] SVC = 5'b10011;
  localparam logic [4:0] SYS = 5'b11111;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [4:0]  mode;
  logic [3:0]  read_0, read_1, read_2;
  logic [31:0] rdata_0, rdata_1, rdata_2;
  logic        busy_0, busy_1, busy_2;
  logic        write_en;
  logic [3:0]  write_reg;
  logic [4:0]  write_mode;
  logic [31:0] write_data;
  logic        set_en;
  logic [3:0]  set_reg;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  always #5 clk = ~clk;

  regfile dut (
    .clk(clk), .rst_b(rst_b), .mode(mode),
    .read_0(read_0), .read_1(read_1), .read_2(read_2),
    .rdata_0(rdata_0), .rdata_1(rdata_1), .rdata_2(rdata_2),
    .busy_0(busy_0), .busy_1(busy_1), .busy_2(busy_2),
    .write_en(write_en), .write_reg(write_reg), .write_mode(write_mode),
    .write_data(write_data), .set_en(set_en), .set_reg(set_reg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] r, input logic [4:0] m, input logic [31:0] d);
    write_en = 1'b1; write_reg = r; write_mode = m; write_data = d;
    tick();
    write_en = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0; mode = USR;
    read_0 = '0; read_1 = '0; read_2 = '0;
    write_en = 1'b0; write_reg = '0; write_mode = USR; write_data = '0;
    set_en = 1'b0; set_reg = '0;

    // Reset then read
    tick();
    rst_b = 1'b1; read_0 = 4'd3; #1;
    check("reset_rdata0", rdata_0, 32'h0);
    check("reset_busy0", {31'b0, busy_0}, 32'h0);

    // r13 banking between SVC and USR/SYS
    do_write(4'd13, SVC, 32'h1111);
    do_write(4'd13, USR, 32'h2222);
    read_0 = 4'd13; read_1 = 4'd13;
    mode = SVC; #1;
    check("svc_r13", rdata_0, 32'h1111);
    check("svc_r13_alias", rdata_1, 32'h1111);
    mode = USR; #1;
    check("usr_r13", rdata_0, 32'h2222);
    mode = SYS; #1;
    check("sys_r13", rdata_0, 32'h2222);

    // FIQ banks r8-r14
    do_write(4'd9, FIQ, 32'hABCD);
    read_0 = 4'd9; read_1 = 4'd13; mode = USR; #1;
    check("usr_r9", rdata_0, 32'h0);
    mode = FIQ; #1;
    check("fiq_r9", rdata_0, 32'hABCD);
    check("fiq_r13", rdata_1, 32'h0);
    mode = 5'b00101; #1;   // unlisted encoding behaves as USR
    check("unlisted_r13", rdata_1, 32'h2222);

    // Same-cycle write bypass
    mode = USR; read_1 = 4'd5;
    write_en = 1'b1; write_reg = 4'd5; write_mode = USR; write_data = 32'hDEAD; #1;
    check("bypass_pre", rdata_1, 32'hDEAD);
    tick();
    write_en = 1'b0; #1;
    check("bypass_post", rdata_1, 32'hDEAD);

    // Scoreboard set / clear / set-wins
    set_en = 1'b1; set_reg = 4'd2;
    tick();
    set_en = 1'b0; read_0 = 4'd2; #1;
    check("sb_set", {31'b0, busy_0}, 32'h1);
    write_en = 1'b1; write_reg = 4'd2; write_mode = USR; write_data = 32'h77; #1;
    check("sb_clear_bypass", {31'b0, busy_0}, 32'h0);
    check("sb_clear_data", rdata_0, 32'h77);
    tick();
    write_en = 1'b0; #1;
    check("sb_clear_after", {31'b0, busy_0}, 32'h0);
    set_en = 1'b1; set_reg = 4'd2;
    write_en = 1'b1; write_reg = 4'd2; write_mode = USR; write_data = 32'h88;
    tick();
    set_en = 1'b0; write_en = 1'b0; #1;
    check("sb_set_wins", {31'b0, busy_0}, 32'h1);
    check("sb_set_wins_data", rdata_0, 32'h88);

    // Banked set: SVC r13 busy does not show in USR
    mode = SVC; set_en = 1'b1; set_reg = 4'd13;
    tick();
    set_en = 1'b0; read_2 = 4'd13; #1;
    check("sb_svc_r13", {31'b0, busy_2}, 32'h1);
    mode = USR; #1;
    check("sb_usr_r13", {31'b0, busy_2}, 32'h0);

    // r15 is never stored and never busy
    read_1 = 4'hF;
    write_en = 1'b1; write_reg = 4'hF; write_mode = USR; write_data = 32'hFFFF_FFFF;
    set_en = 1'b1; set_reg = 4'hF; #1;
    check("pc_bypass", rdata_1, 32'h0);
    tick();
    write_en = 1'b0; set_en = 1'b0; #1;
    check("pc_rdata", rdata_1, 32'h0);
    check("pc_busy", {31'b0, busy_1}, 32'h0);

    // Reset mid-operation with r2 busy and pending write/set
    read_0 = 4'd2; read_1 = 4'd4; read_2 = 4'd13;
    rst_b = 1'b0;
    write_en = 1'b1; write_reg = 4'd2; write_mode = USR; write_data = 32'h1234;
    set_en = 1'b1; set_reg = 4'd4;
    tick();
    rst_b = 1'b1; write_en = 1'b0; set_en = 1'b0; #1;
    check("rst_r2_busy", {31'b0, busy_0}, 32'h0);
    check("rst_r2_data", rdata_0, 32'h0);
    check("rst_r4_busy", {31'b0, busy_1}, 32'h0);
    mode = SVC; #1;
    check("rst_svc_r13_busy", {31'b0, busy_2}, 32'h0);
    check("rst_svc_r13_data", rdata_2, 32'h0);

    // Writeback after reset stores normally
    mode = USR;
    do_write(4'd2, USR, 32'h55);
    #1;
    check("post_rst_data", rdata_0, 32'h55);
    check("post_rst_busy", {31'b0, busy_0}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
